// File: rtl/neighbor_builder.sv
// Builds per-vertex neighbour lists from a triangle mesh held in object RAM,
// writing count + first-insertion-ordered 1-based neighbour indices into neighbour RAM.
module neighbor_builder #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    output logic                  RAM_OBJ_EN,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [31:0]           RAM_OBJ_Di,
    input  logic [31:0]           RAM_OBJ_Do,
    output logic                  RAM_NBR_EN,
    output logic [3:0]            RAM_NBR_WE,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [31:0]           RAM_NBR_Di,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  bad_index
);
    typedef enum logic [3:0] {
        IDLE, CLEAR, FACE_RD, PAIR, CNT_RD, SCAN, APPEND, CNT_WR, DONE
    } state_t;

    localparam logic [31:0] M32 = 32'(MAX_NEIGHBOR_COUNT);

    state_t                  state_q;
    logic [31:0]             vc_q, fc_q, face_q, k_q;
    logic [31:0]             a_q, b_q, c_q, nb_q, base_q, n_q, j_q;
    logic [2:0]              pair_q;
    logic [1:0]              sub_q;
    logic                    obj_en_q, nbr_en_q;
    logic [ADDR_WIDTH-1:0]   obj_a_q, nbr_a_q;
    logic [3:0]              nbr_we_q;
    logic [31:0]             nbr_di_q;
    logic                    busy_q, done_q, ovf_q, bad_q;

    logic [31:0] tgt_d, nb_d, face_base_d, face_addr_d, face_nxt_addr_d;
    logic        last_face_d, bad_face_d;

    always_comb begin
        tgt_d = '0;
        nb_d  = '0;
        case (pair_q)
            3'd0: begin tgt_d = a_q; nb_d = b_q; end
            3'd1: begin tgt_d = a_q; nb_d = c_q; end
            3'd2: begin tgt_d = b_q; nb_d = a_q; end
            3'd3: begin tgt_d = b_q; nb_d = c_q; end
            3'd4: begin tgt_d = c_q; nb_d = a_q; end
            3'd5: begin tgt_d = c_q; nb_d = b_q; end
            default: ;
        endcase
    end

    assign face_base_d     = 32'd3 * vc_q + 32'd1;
    assign face_addr_d     = face_base_d + 32'd3 * face_q;
    assign face_nxt_addr_d = face_base_d + 32'd3 * (face_q + 32'd1);
    assign last_face_d     = (face_q + 32'd1 == fc_q);
    // The third index is still on the read bus when the face is validated.
    assign bad_face_d = (a_q == 32'd0) || (a_q > vc_q) ||
                        (b_q == 32'd0) || (b_q > vc_q) ||
                        (RAM_OBJ_Do == 32'd0) || (RAM_OBJ_Do > vc_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vc_q     <= '0;  fc_q <= '0;  face_q <= '0;  k_q <= '0;
            a_q      <= '0;  b_q  <= '0;  c_q    <= '0;  nb_q <= '0;
            base_q   <= '0;  n_q  <= '0;  j_q    <= '0;
            pair_q   <= '0;  sub_q <= '0;
            obj_en_q <= 1'b0; obj_a_q <= '0;
            nbr_en_q <= 1'b0; nbr_a_q <= '0; nbr_we_q <= '0; nbr_di_q <= '0;
            busy_q   <= 1'b0; done_q <= 1'b0; ovf_q <= 1'b0; bad_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vc_q    <= vertex_count;
                        fc_q    <= face_count;
                        ovf_q   <= 1'b0;
                        bad_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        face_q  <= '0;
                        k_q     <= '0;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (k_q < vc_q) begin
                        nbr_en_q <= 1'b1;
                        nbr_we_q <= 4'b1111;
                        nbr_a_q  <= ADDR_WIDTH'(k_q * M32);
                        nbr_di_q <= '0;
                        k_q      <= k_q + 32'd1;
                    end else begin
                        nbr_en_q <= 1'b0;
                        nbr_we_q <= '0;
                        if (fc_q == 32'd0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            obj_en_q <= 1'b1;
                            obj_a_q  <= ADDR_WIDTH'(face_addr_d);
                            sub_q    <= '0;
                            state_q  <= FACE_RD;
                        end
                    end
                end
                FACE_RD: begin
                    case (sub_q)
                        2'd0: begin
                            obj_a_q <= ADDR_WIDTH'(face_addr_d + 32'd1);
                            sub_q   <= 2'd1;
                        end
                        2'd1: begin
                            a_q     <= RAM_OBJ_Do;
                            obj_a_q <= ADDR_WIDTH'(face_addr_d + 32'd2);
                            sub_q   <= 2'd2;
                        end
                        2'd2: begin
                            b_q      <= RAM_OBJ_Do;
                            obj_en_q <= 1'b0;
                            sub_q    <= 2'd3;
                        end
                        default: begin
                            c_q <= RAM_OBJ_Do;
                            if (bad_face_d) begin
                                bad_q  <= 1'b1;
                                face_q <= face_q + 32'd1;
                                if (last_face_d) begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= DONE;
                                end else begin
                                    obj_en_q <= 1'b1;
                                    obj_a_q  <= ADDR_WIDTH'(face_nxt_addr_d);
                                    sub_q    <= '0;
                                end
                            end else begin
                                pair_q  <= '0;
                                state_q <= PAIR;
                            end
                        end
                    endcase
                end
                PAIR: begin
                    if (pair_q == 3'd6) begin
                        face_q <= face_q + 32'd1;
                        if (last_face_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            obj_en_q <= 1'b1;
                            obj_a_q  <= ADDR_WIDTH'(face_nxt_addr_d);
                            sub_q    <= '0;
                            state_q  <= FACE_RD;
                        end
                    end else if (tgt_d == nb_d) begin
                        pair_q <= pair_q + 3'd1;
                    end else begin
                        base_q   <= (tgt_d - 32'd1) * M32;
                        nb_q     <= nb_d;
                        nbr_en_q <= 1'b1;
                        nbr_a_q  <= ADDR_WIDTH'((tgt_d - 32'd1) * M32);
                        sub_q    <= '0;
                        state_q  <= CNT_RD;
                    end
                end
                CNT_RD: begin
                    if (sub_q == 2'd0) begin
                        nbr_en_q <= 1'b0;
                        sub_q    <= 2'd1;
                    end else begin
                        n_q <= RAM_NBR_Do;
                        if (RAM_NBR_Do == 32'd0) begin
                            nbr_en_q <= 1'b1;
                            nbr_we_q <= 4'b1111;
                            nbr_a_q  <= ADDR_WIDTH'(base_q + 32'd1);
                            nbr_di_q <= nb_q;
                            state_q  <= APPEND;
                        end else begin
                            j_q      <= 32'd1;
                            nbr_en_q <= 1'b1;
                            nbr_a_q  <= ADDR_WIDTH'(base_q + 32'd1);
                            sub_q    <= '0;
                            state_q  <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (sub_q == 2'd0) begin
                        nbr_en_q <= 1'b0;
                        sub_q    <= 2'd1;
                    end else if (RAM_NBR_Do == nb_q) begin
                        pair_q  <= pair_q + 3'd1;
                        state_q <= PAIR;
                    end else if (j_q == n_q) begin
                        if (n_q < M32 - 32'd1) begin
                            nbr_en_q <= 1'b1;
                            nbr_we_q <= 4'b1111;
                            nbr_a_q  <= ADDR_WIDTH'(base_q + n_q + 32'd1);
                            nbr_di_q <= nb_q;
                            state_q  <= APPEND;
                        end else begin
                            ovf_q   <= 1'b1;
                            pair_q  <= pair_q + 3'd1;
                            state_q <= PAIR;
                        end
                    end else begin
                        j_q      <= j_q + 32'd1;
                        nbr_en_q <= 1'b1;
                        nbr_a_q  <= ADDR_WIDTH'(base_q + j_q + 32'd1);
                        sub_q    <= '0;
                    end
                end
                APPEND: begin
                    nbr_a_q  <= ADDR_WIDTH'(base_q);
                    nbr_di_q <= n_q + 32'd1;
                    state_q  <= CNT_WR;
                end
                CNT_WR: begin
                    nbr_en_q <= 1'b0;
                    nbr_we_q <= '0;
                    pair_q   <= pair_q + 3'd1;
                    state_q  <= PAIR;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RAM_OBJ_EN = obj_en_q;
    assign RAM_OBJ_WE = '0;
    assign RAM_OBJ_A  = obj_a_q;
    assign RAM_OBJ_Di = '0;
    assign RAM_NBR_EN = nbr_en_q;
    assign RAM_NBR_WE = nbr_we_q;
    assign RAM_NBR_A  = nbr_a_q;
    assign RAM_NBR_Di = nbr_di_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign bad_index  = bad_q;
endmodule

// File: tb/tb_neighbor_builder.sv
// Directed bench for neighbor_builder: behavioural object/neighbour RAMs and
// hand-computed slot contents for small meshes, overflow, bad indices and reset.
module tb_neighbor_builder;
    localparam int M  = 10;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   vertex_count = '0;
    logic [31:0]   face_count = '0;
    logic          RAM_OBJ_EN, RAM_NBR_EN;
    logic [3:0]    RAM_OBJ_WE, RAM_NBR_WE;
    logic [AW-1:0] RAM_OBJ_A, RAM_NBR_A;
    logic [31:0]   RAM_OBJ_Di, RAM_NBR_Di;
    logic [31:0]   obj_do = '0;
    logic [31:0]   nbr_do = '0;
    logic          busy, done, overflow, bad_index;

    logic [31:0]   obj_mem [0:511];
    logic [31:0]   nbr_mem [0:511];
    logic          fill_req = 1'b0;
    int            nbr_wr_cnt = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(M), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_OBJ_WE(RAM_OBJ_WE), .RAM_OBJ_A(RAM_OBJ_A),
        .RAM_OBJ_Di(RAM_OBJ_Di), .RAM_OBJ_Do(obj_do),
        .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_WE(RAM_NBR_WE), .RAM_NBR_A(RAM_NBR_A),
        .RAM_NBR_Di(RAM_NBR_Di), .RAM_NBR_Do(nbr_do),
        .busy(busy), .done(done), .overflow(overflow), .bad_index(bad_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RAM_OBJ_EN) obj_do <= obj_mem[RAM_OBJ_A];
        if (fill_req) begin
            for (int i = 0; i < 512; i++) nbr_mem[i] <= 32'hFFFF_FFFF;
        end else if (RAM_NBR_EN) begin
            if (RAM_NBR_WE == 4'hF) begin
                nbr_mem[RAM_NBR_A] <= RAM_NBR_Di;
                nbr_wr_cnt <= nbr_wr_cnt + 1;
            end
            nbr_do <= nbr_mem[RAM_NBR_A];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_slot(input string tag, input int addr, input logic [31:0] exp);
        check($sformatf("%s_nbr[%0d]", tag, addr), nbr_mem[addr], exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_done"},    32'(done), 32'd0);
        check({tag, "_ovf"},     32'(overflow), 32'd0);
        check({tag, "_bad"},     32'(bad_index), 32'd0);
        check({tag, "_nbr_en"},  32'(RAM_NBR_EN), 32'd0);
        check({tag, "_nbr_we"},  32'(RAM_NBR_WE), 32'd0);
        check({tag, "_nbr_a"},   32'(RAM_NBR_A), 32'd0);
        check({tag, "_nbr_di"},  RAM_NBR_Di, 32'd0);
        check({tag, "_obj_en"},  32'(RAM_OBJ_EN), 32'd0);
        check({tag, "_obj_a"},   32'(RAM_OBJ_A), 32'd0);
    endtask

    task automatic fill_nbr();
        @(negedge clk) fill_req = 1'b1;
        @(negedge clk) fill_req = 1'b0;
    endtask

    task automatic set_face(input int vc, input int f, input int a, input int b, input int c);
        int base;
        base = 3 * vc + 1 + 3 * f;
        obj_mem[base]     = 32'(a);
        obj_mem[base + 1] = 32'(b);
        obj_mem[base + 2] = 32'(c);
    endtask

    task automatic run_build(input string tag, input logic [31:0] vc, input logic [31:0] fc,
                             input bit poke);
        bit seen;
        @(negedge clk);
        vertex_count = vc;
        face_count   = fc;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        if (poke) begin
            vertex_count = vc + 32'd2;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int cyc = 0; cyc < 5000 && !seen; cyc++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic check_tri_result(input string tag);
        check_slot(tag, 0, 32'd2);  check_slot(tag, 1, 32'd2);  check_slot(tag, 2, 32'd3);
        check_slot(tag, 10, 32'd2); check_slot(tag, 11, 32'd1); check_slot(tag, 12, 32'd3);
        check_slot(tag, 20, 32'd2); check_slot(tag, 21, 32'd1); check_slot(tag, 22, 32'd2);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_bad"}, 32'(bad_index), 32'd0);
    endtask

    initial begin
        int wr0;
        for (int i = 0; i < 512; i++) obj_mem[i] = 32'h0BAD_0000 + 32'(i);

        // Reset held with start high: start must be ignored.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check({"reset_release", "_busy"}, 32'(busy), 32'd0);

        // Single triangle.
        fill_nbr();
        set_face(3, 0, 1, 2, 3);
        run_build("tri", 32'd3, 32'd1, 1'b0);
        check_tri_result("tri");

        // Two faces sharing edge 1-3.
        fill_nbr();
        set_face(4, 0, 1, 2, 3);
        set_face(4, 1, 1, 3, 4);
        run_build("quad", 32'd4, 32'd2, 1'b0);
        check_slot("quad", 0, 32'd3);  check_slot("quad", 1, 32'd2);
        check_slot("quad", 2, 32'd3);  check_slot("quad", 3, 32'd4);
        check_slot("quad", 4, 32'hFFFF_FFFF);
        check_slot("quad", 10, 32'd2); check_slot("quad", 11, 32'd1);
        check_slot("quad", 12, 32'd3);
        check_slot("quad", 20, 32'd3); check_slot("quad", 21, 32'd1);
        check_slot("quad", 22, 32'd2); check_slot("quad", 23, 32'd4);
        check_slot("quad", 30, 32'd2); check_slot("quad", 31, 32'd1);
        check_slot("quad", 32, 32'd3);
        check("quad_ovf", 32'(overflow), 32'd0);

        // Fan around vertex 1 overflows its slot.
        fill_nbr();
        for (int k = 2; k <= 11; k++) set_face(12, k - 2, 1, k, k + 1);
        run_build("fan", 32'd12, 32'd10, 1'b0);
        check_slot("fan", 0, 32'd9);
        check_slot("fan", 1, 32'd2);
        check_slot("fan", 9, 32'd10);
        check_slot("fan", 10, 32'd2);
        check_slot("fan", 100, 32'd3);
        check_slot("fan", 101, 32'd1);
        check_slot("fan", 102, 32'd10);
        check_slot("fan", 103, 32'd12);
        check_slot("fan", 110, 32'd2);
        check("fan_ovf", 32'(overflow), 32'd1);
        check("fan_bad", 32'(bad_index), 32'd0);

        // Out-of-range index: face skipped, flags from the previous build cleared.
        fill_nbr();
        set_face(3, 0, 1, 5, 2);
        @(negedge clk);
        wr0 = nbr_wr_cnt;
        run_build("badidx", 32'd3, 32'd1, 1'b0);
        check("badidx_writes", 32'(nbr_wr_cnt - wr0), 32'd3);
        check_slot("badidx", 0, 32'd0);
        check_slot("badidx", 10, 32'd0);
        check_slot("badidx", 20, 32'd0);
        check_slot("badidx", 1, 32'hFFFF_FFFF);
        check("badidx_bad", 32'(bad_index), 32'd1);
        check("badidx_ovf", 32'(overflow), 32'd0);

        // No faces, plus a second start while busy.
        fill_nbr();
        @(negedge clk);
        wr0 = nbr_wr_cnt;
        run_build("nofaces", 32'd5, 32'd0, 1'b1);
        check("nofaces_writes", 32'(nbr_wr_cnt - wr0), 32'd5);
        for (int v = 0; v < 5; v++) check_slot("nofaces", v * M, 32'd0);
        check_slot("nofaces", 50, 32'hFFFF_FFFF);
        check("nofaces_bad", 32'(bad_index), 32'd0);
        @(negedge clk);
        check("nofaces_idle", 32'(busy), 32'd0);

        // Reset during the first scan of a build, then a clean rebuild.
        fill_nbr();
        set_face(3, 0, 1, 2, 3);
        @(negedge clk);
        vertex_count = 32'd3;
        face_count   = 32'd1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("midrst");
        rst_n = 1'b1;
        fill_nbr();
        run_build("rebuild", 32'd3, 32'd1, 1'b0);
        check_tri_result("rebuild");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/neighbor_builder.md
NEIGHBOR_BUILDER -- requirements
Module: neighbor_builder

Interface
REQ-001 Parameter MAX_NEIGHBOR_COUNT, default 10: words per vertex slot in neighbour RAM (slot word 0 = count, words 1..M-1 = neighbours).
REQ-002 Parameter ADDR_WIDTH, default 9: RAM address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  begin build; sampled only in IDLE.
REQ-006 vertex_count, face_count  in  32 each  mesh sizes, sampled on accepted start.
REQ-007 RAM_OBJ_EN/RAM_OBJ_WE/RAM_OBJ_A/RAM_OBJ_Di  out  1/4/ADDR_WIDTH/32  object RAM port (read-only use, WE held 0, Di held 0).
REQ-008 RAM_OBJ_Do  in  32  object RAM read data.
REQ-009 RAM_NBR_EN/RAM_NBR_WE/RAM_NBR_A/RAM_NBR_Di  out  1/4/ADDR_WIDTH/32  neighbour RAM port.
REQ-010 RAM_NBR_Do  in  32  neighbour RAM read data.
REQ-011 busy  out  1  high from accepted start until done.
REQ-012 done  out  1  one-cycle pulse at build completion.
REQ-013 overflow  out  1  sticky: a neighbour was dropped because a slot was full.
REQ-014 bad_index  out  1  sticky: a face held an index of 0 or > vertex_count.

Function
REQ-015 RAM model: read data valid on Do one cycle after A presented with EN=1, WE=0; write committed on the edge where EN=1, WE=4'b1111.
REQ-016 Object RAM layout: address 0 unused; vertex k (1-based) at 3k-2..3k; face f (0-based) at FACE_BASE+3f..+2, FACE_BASE = 3*vertex_count+1; face words are 1-based vertex indices.
REQ-017 Neighbour RAM layout: vertex k slot base = (k-1)*MAX_NEIGHBOR_COUNT; stored neighbour values are 1-based indices; the downstream averager consumes this layout unchanged.
REQ-018 States: IDLE, CLEAR, FACE_RD, PAIR, CNT_RD, SCAN, APPEND, CNT_WR, DONE.
REQ-019 IDLE: start=1 -> clear overflow, bad_index; busy=1; go CLEAR. start while busy is ignored.
REQ-020 CLEAR: write 0 to each slot base, one write per cycle, vertex 1..vertex_count; then FACE_RD (or DONE if face_count=0).
REQ-021 FACE_RD: read three index words of current face into a,b,c.
REQ-022 If any of a,b,c is 0 or > vertex_count: set bad_index, skip face, no NBR writes.
REQ-023 PAIR: iterate six ordered pairs (a,b),(a,c),(b,a),(b,c),(c,a),(c,b) as (target,neighbour); pairs with target==neighbour are skipped.
REQ-024 CNT_RD: read count n of target slot.
REQ-025 SCAN: read entries 1..n of target; any entry equal to neighbour -> pair done, no write.
REQ-026 APPEND: no match and n < MAX_NEIGHBOR_COUNT-1 -> write neighbour at base+n+1; CNT_WR writes n+1 to base.
REQ-027 No match and n == MAX_NEIGHBOR_COUNT-1 -> set overflow, drop pair, count unchanged.
REQ-028 After sixth pair, advance face; after face_count faces -> DONE.
REQ-029 DONE: done=1 for exactly one cycle, busy=0, RAM EN/WE deasserted, return IDLE.
REQ-030 Entry order within a slot = first-insertion order over faces ascending, pairs in REQ-023 order.
REQ-031 Address arithmetic computed at full 32-bit width then truncated to ADDR_WIDTH; out-of-range sizes are caller error.
REQ-032 Outputs registered; RAM_NBR_WE nonzero only in CLEAR, APPEND, CNT_WR.

Reset
REQ-033 rst_n=0 at any edge, including mid-build: next state IDLE; busy, done, overflow, bad_index = 0; all RAM EN, WE, A, Di = 0; partial RAM contents undefined.
REQ-034 start coincident with rst_n=0 is ignored.

Verification
REQ-035 vertex_count=3, face_count=1, face (1,2,3) -> NBR[0]=2,[1]=2,[2]=3; NBR[10]=2,[11]=1,[12]=3; NBR[20]=2,[21]=1,[22]=2; done pulse once; overflow=0.
REQ-036 vertex_count=4, faces (1,2,3),(1,3,4) -> vertex 1 count 3 = {2,3,4}; vertex 3 count 3 = {1,2,4}; vertex 2 count 2; vertex 4 count 2; no duplicates.
REQ-037 Fan of 10 triangles (1,k,k+1), k=2..11, vertex_count=12 -> NBR[0]=9 (entries 2..10), overflow=1.
REQ-038 Face (1,5,2) with vertex_count=3 -> bad_index=1, no writes beyond CLEAR, counts all 0.
REQ-039 face_count=0, vertex_count=5 -> five zero writes at 0,10,20,30,40 then done; second start during busy ignored.
REQ-040 rst_n low mid-SCAN -> next cycle IDLE, all outputs 0; subsequent start rebuilds REQ-035 result exactly.
